// File: rtl/serial_set_less_than_if.sv
// Request/response bundle for the bit-serial set-less-than unit.
// The master issues start with the operands; the slave returns busy, done and result.
interface serial_set_less_than_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             is_signed;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, a, b, is_signed,
        input  busy, done, result
    );

    modport slave (
        input  start, a, b, is_signed,
        output busy, done, result
    );
endinterface

// File: rtl/serial_set_less_than.sv
// Bit-serial SLT/SLTU: compares latched operands MSB-first, one bit per clock.
// Optional macro SERIAL_SLT_EARLY_EXIT_EN finishes on the first differing bit.
module serial_set_less_than #(
    parameter int WIDTH = 32,
    parameter int IDX_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    serial_set_less_than_if.slave bus
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COMPARE = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             sgn_q;
    logic [IDX_W-1:0] idx;
    logic             res_lt;
`ifndef SERIAL_SLT_EARLY_EXIT_EN
    logic             found_q;
    logic             lt_q;
`endif

    logic bit_a;
    logic bit_b;
    logic diff;
    logic lt_now;

    // Operands shift left each compare cycle, so the bit under test is always the MSB.
    assign bit_a = a_sh[WIDTH-1];
    assign bit_b = b_sh[WIDTH-1];
    assign diff  = bit_a ^ bit_b;

    // At the sign position a signed compare inverts the sense: a negative a is smaller.
    always_comb begin
        lt_now = bit_b;
        if (idx == IDX_MSB && sgn_q)
            lt_now = bit_a;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            sgn_q   <= 1'b0;
            idx     <= '0;
            res_lt  <= 1'b0;
`ifndef SERIAL_SLT_EARLY_EXIT_EN
            found_q <= 1'b0;
            lt_q    <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        a_sh    <= bus.a;
                        b_sh    <= bus.b;
                        sgn_q   <= bus.is_signed;
                        idx     <= IDX_MSB;
                        state   <= S_COMPARE;
`ifndef SERIAL_SLT_EARLY_EXIT_EN
                        found_q <= 1'b0;
                        lt_q    <= 1'b0;
`endif
                    end
                end
                S_COMPARE: begin
                    a_sh <= a_sh << 1;
                    b_sh <= b_sh << 1;
                    if (idx != '0)
                        idx <= idx - 1'b1;
`ifdef SERIAL_SLT_EARLY_EXIT_EN
                    if (diff) begin
                        res_lt <= lt_now;
                        state  <= S_DONE;
                    end else if (idx == '0) begin
                        res_lt <= 1'b0;
                        state  <= S_DONE;
                    end
`else
                    // First difference wins; later bits are scanned but ignored.
                    if (!found_q && diff) begin
                        found_q <= 1'b1;
                        lt_q    <= lt_now;
                    end
                    if (idx == '0) begin
                        res_lt <= found_q ? lt_q : (diff & lt_now);
                        state  <= S_DONE;
                    end
`endif
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = (state != S_IDLE);
    assign bus.done   = (state == S_DONE);
    assign bus.result = {{(WIDTH-1){1'b0}}, res_lt};

endmodule

// File: tb/tb_serial_set_less_than.sv
// Self-checking bench for serial_set_less_than against a behavioural compare model.
// Expected latencies follow the SERIAL_SLT_EARLY_EXIT_EN build setting.
module tb_serial_set_less_than;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    serial_set_less_than_if #(.WIDTH(W)) bus ();

    serial_set_less_than #(.WIDTH(W), .IDX_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference: plain arithmetic compare, zero-extended.
    function automatic logic [W-1:0] model_res(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic s);
        logic lt;
        if (s) lt = ($signed(a) < $signed(b));
        else   lt = (a < b);
        return {{(W-1){1'b0}}, lt};
    endfunction

    // Cycle (counting the accepting cycle as 0) in which done is expected.
    function automatic int model_lat(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SERIAL_SLT_EARLY_EXIT_EN
        for (int i = W - 1; i >= 0; i--)
            if (a[i] != b[i]) return W - i + 1;
        return W + 1;
`else
        return W + 1;
`endif
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          output logic [W-1:0] res, output int lat);
        bus.start = 1'b1; bus.a = a; bus.b = b; bus.is_signed = s;
        @(negedge clk);
        bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom; bus.is_signed = ~s;
        lat = 1;
        while (bus.done !== 1'b1 && lat < W + 10) begin
            @(negedge clk);
            lat++;
        end
        if (bus.done !== 1'b1) lat = -1;
        res = bus.result;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.is_signed = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== '0) begin
            fails++;
            $display("FAIL reset: busy=%b done=%b result=%h, required 0 0 0", bus.busy, bus.done, bus.result);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed;
        logic [W-1:0] av [8];
        logic [W-1:0] bv [8];
        logic         sv [8];
        logic [W-1:0] ev [8];
        logic [W-1:0] res;
        int lat;
        av = '{32'd4294000000, 32'd4294000001, 32'd12, 32'd21, 32'h80000000, 32'h80000000, 32'hFFF13D80, 32'h00001234};
        bv = '{32'd4294000001, 32'd4294000000, 32'd21, 32'd12, 32'd1,        32'd1,        32'hFFF13D81, 32'h00001234};
        sv = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        ev = '{32'd1, 32'd0, 32'd1, 32'd0, 32'd1, 32'd0, 32'd1, 32'd0};
        for (int i = 0; i < 8; i++) begin
            run_op(av[i], bv[i], sv[i], res, lat);
            tests++;
            if (res !== ev[i]) begin
                fails++;
                $display("FAIL directed_result[%0d]: got %h, required %h", i, res, ev[i]);
            end
            tests++;
            if (lat !== model_lat(av[i], bv[i])) begin
                fails++;
                $display("FAIL directed_latency[%0d]: done in cycle %0d, required %0d", i, lat, model_lat(av[i], bv[i]));
            end
        end
        // Result must hold after the DONE cycle.
        tests++;
        if (bus.result !== 32'd0 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL hold_after_done: result=%h busy=%b, required 0 0", bus.result, bus.busy);
        end
    endtask

    task automatic test_small_latency;
        logic [W-1:0] res;
        int lat;
        int req;
`ifdef SERIAL_SLT_EARLY_EXIT_EN
        req = 29;
`else
        req = 33;
`endif
        run_op(32'd12, 32'd21, 1'b0, res, lat);
        tests++;
        if (lat !== req || res !== 32'd1) begin
            fails++;
            $display("FAIL small_latency: cycle %0d result %h, required cycle %0d result 1", lat, res, req);
        end
    endtask

    task automatic test_ignore_start;
        int cyc;
        bus.start = 1'b1; bus.a = 32'h1234; bus.b = 32'h1234; bus.is_signed = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        while (bus.done !== 1'b1 && cyc < W + 10) begin
            @(negedge clk);
            cyc++;
            if (cyc == 5) begin
                bus.start = 1'b1; bus.a = 32'd0; bus.b = 32'd1; bus.is_signed = 1'b0;
            end else begin
                bus.start = 1'b0;
            end
        end
        tests++;
        if (bus.done !== 1'b1 || cyc !== W + 1 || bus.result !== 32'd0) begin
            fails++;
            $display("FAIL ignore_start: done=%b cycle %0d result %h, required done in cycle %0d result 0",
                     bus.done, cyc, bus.result, W + 1);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tests++;
            if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'd0) begin
                fails++;
                $display("FAIL not_queued[%0d]: busy=%b done=%b result=%h, required 0 0 0",
                         k, bus.busy, bus.done, bus.result);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [W-1:0] res;
        int lat;
        int seen;
        run_op(32'd3, 32'd9, 1'b0, res, lat);
        bus.start = 1'b1; bus.a = 32'd5; bus.b = 32'd7; bus.is_signed = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'd0) begin
            fails++;
            $display("FAIL reset_mid: busy=%b done=%b result=%h, required 0 0 0", bus.busy, bus.done, bus.result);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (W + 4) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen++;
        end
        tests++;
        if (seen != 0) begin
            fails++;
            $display("FAIL no_done_after_reset: %0d done pulses, required 0", seen);
        end
        run_op(32'hFFFFFFFE, 32'd2, 1'b1, res, lat);
        tests++;
        if (res !== 32'd1 || lat !== model_lat(32'hFFFFFFFE, 32'd2)) begin
            fails++;
            $display("FAIL restart_after_reset: result %h cycle %0d, required 1 cycle %0d",
                     res, lat, model_lat(32'hFFFFFFFE, 32'd2));
        end
    endtask

    task automatic test_random;
        logic [W-1:0] a, b, res;
        logic s;
        int lat;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            case (i % 4)
                0: b = $urandom;
                1: b = a ^ (32'd1 << $urandom_range(0, W - 1));
                2: b = a;
                default: b = {a[W-1:16], 16'($urandom)};
            endcase
            s = 1'($urandom);
            run_op(a, b, s, res, lat);
            tests++;
            if (res !== model_res(a, b, s) || lat !== model_lat(a, b)) begin
                fails++;
                $display("FAIL random[%0d] a=%h b=%h s=%b: result %h cycle %0d, required %h cycle %0d",
                         i, a, b, s, res, lat, model_res(a, b, s), model_lat(a, b));
            end
        end
    endtask

    task automatic test_back_to_back;
        int next_accept;
        int done_at;
        logic [W-1:0] exp_res;
        int ndone;
        next_accept = 0;
        done_at = -1;
        exp_res = '0;
        ndone = 0;
        for (int c = 0; c < 6 * (W + 2); c++) begin
            if (c > 0) begin
                tests++;
                if (bus.done !== (c == done_at)) begin
                    fails++;
                    $display("FAIL b2b_done cycle %0d: done=%b, required %b", c, bus.done, (c == done_at));
                end
                if (c == done_at) begin
                    ndone++;
                    tests++;
                    if (bus.result !== exp_res) begin
                        fails++;
                        $display("FAIL b2b_result cycle %0d: got %h, required %h", c, bus.result, exp_res);
                    end
                end
            end
            bus.start = 1'b1;
            bus.a = $urandom;
            bus.b = (c % 2) ? bus.a ^ (32'd1 << $urandom_range(0, W - 1)) : $urandom;
            bus.is_signed = 1'($urandom);
            if (c == next_accept) begin
                exp_res = model_res(bus.a, bus.b, bus.is_signed);
                done_at = c + model_lat(bus.a, bus.b);
                next_accept = done_at + 1;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        tests++;
        if (ndone < 5) begin
            fails++;
            $display("FAIL b2b_count: %0d done pulses checked, required at least 5", ndone);
        end
        repeat (W + 4) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_small_latency();
        test_ignore_start();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/serial_set_less_than.md
Name: serial_set_less_than

Overview:
- Multi-cycle, bit-serial SLT/SLTU unit for the ALU's slow path.
- Compares two WIDTH-bit operands MSB-first, one bit per clock, behind a start/busy/done handshake.
- Returns the MIPS SLT-format result: zero-extended, with bit 0 = "a < b".
- Serves as the area-reduced alternative to the combinational set-less-than and as a cross-check against it.

Parameters:
- WIDTH, 32, operand and result width; legal values 2..64.
- IDX_W, 5, width of the bit-index counter; must satisfy 2^IDX_W >= WIDTH.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  left operand; latched when start is accepted.
- b  input  WIDTH  right operand; latched when start is accepted.
- is_signed  input  1  1 = SLT (two's complement), 0 = SLTU; latched with the operands.
- busy  output  1  high in COMPARE and DONE.
- done  output  1  one-cycle pulse in the DONE state.
- result  output  WIDTH  {WIDTH-1 zeros, lt}; held until the next DONE.

Behaviour:
- Reset (async assert, deassert sampled on clk):
  - state=IDLE, busy=0, done=0, result=0.
  - Operand registers and index counter cleared.
- IDLE:
  - If start=1 at the edge: latch a, b, is_signed; idx=WIDTH-1; go to COMPARE.
- COMPARE, one edge per bit, examining bit idx of the latched operands:
  - idx = WIDTH-1 (sign bit) and bits differ:
    - Decide lt = a[msb] if signed, lt = b[msb] if unsigned.
  - Any other idx with bits differ: decide lt = b[idx].
  - Bits equal and idx = 0: decide lt = 0 (operands equal).
  - Bits equal and idx > 0: idx decrements; stay in COMPARE.
  - On a decision, go to DONE with result={0..,lt} registered.
- Exit from COMPARE:
  - Baseline (no early exit): decision is recorded at the first differing bit, but the state stays in COMPARE until idx=0.
  - Latency is therefore data-independent: start high in cycle 0 → COMPARE in cycles 1..WIDTH → done=1 in cycle WIDTH+1.
  - Once a decision is recorded, later bits are ignored.
- DONE: done=1 and busy=1 for exactly one cycle; next state is IDLE.
- start while busy (COMPARE or DONE): ignored, not queued.
  - The earliest accepted restart is start high in the cycle after DONE.
- Input stability: operand or is_signed changes after acceptance have no effect.
- Reset mid-COMPARE: immediate return to IDLE; done never pulses; result=0.
- result is stable outside DONE-entry edges and never glitches during COMPARE.

Optional Feature:
- Macro: SERIAL_SLT_EARLY_EXIT_EN.
- Defined: COMPARE goes to DONE on the same edge the first differing bit is found.
  - First difference at bit i → done in cycle WIDTH-i+1.
  - Equal operands still take the full WIDTH cycles.
- Undefined: fixed WIDTH+1-cycle latency as in Behaviour.
- result values are identical in both builds.

Test Plan:
- Unsigned: a=4294000000, b=4294000001, is_signed=0 → result=1, done in cycle 33; swap operands → result=0.
- Small values: a=12, b=21 → 1; a=21, b=12 → 0.
  - With SERIAL_SLT_EARLY_EXIT_EN, first difference is at bit 4 → done in cycle 29; without it, cycle 33.
- Sign handling: a=0x80000000, b=1:
  - is_signed=1 → 1, is_signed=0 → 0.
  - a=0xFFF13D80, b=0xFFF13D81, signed → 1.
- Equal operands: a=b=0x00001234 → result=0, done in cycle 33 in both builds.
  - A start pulse in cycle 5 with different operands is ignored and the result is unchanged.
- Reset mid-operation: rst_n low in cycle 10 of a compare → busy=0, done=0, result=0 asynchronously; no done pulse follows.
  - A fresh start after release completes normally with the correct result.
- Back-to-back: start held high continuously → accepts every WIDTH+2 cycles, one done pulse per accepted request, results match the operands latched at each acceptance.
